gcd_multimode_engine: RTL and testbench

Parametrised successor to the fixed-width GCD unit used behind the SPI register bank.
- Computes GCD of two WIDTH-bit unsigned operands.
- Algorithm is selectable per operation: subtractive Euclid or binary (Stein).
- Valid/ready handshakes on both input and result sides.
- An iteration counter and a timeout-abort bound the latency, so the SPI master can poll status.

---
 rtl/gcd_multimode_engine.sv | 192 +++++++++++++++++++
 tb/tb_gcd_multimode_engine.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_multimode_engine.sv
// gcd_multimode_engine
//   Computes the GCD of two WIDTH-bit unsigned operands. Each operation selects
//   its algorithm with mode_i: subtractive Euclid (0) or binary Stein (1).
//   The engine runs one algorithm step per CALC cycle. An iteration counter
//   bounds the latency: if the counter reaches MAX_ITER before the result is
//   found, the operation aborts and reports a timeout error.
//
// Ports
//   clk_i         clock; all state changes on the rising edge
//   nreset_i      asynchronous active-low reset
//   clear_i       synchronous abort to IDLE; has priority over start/ready
//   start_i       operands valid (accepted only while ready_o is high)
//   ready_o       engine idle and accepting operands
//   mode_i        0 = subtractive Euclid, 1 = binary Stein
//   operand_a_i   operand A
//   operand_b_i   operand B
//   busy_o        calculation in progress
//   gcd_o         result; held until the next operation completes
//   gcd_valid_o   result valid
//   gcd_ready_i   result consumed
//   gcd_error_o   timeout abort flag, qualified by gcd_valid_o
//   iter_count_o  CALC cycles used by the last completed operation
module gcd_multimode_engine #(
    parameter int WIDTH    = 8,
    parameter int MAX_ITER = 2**WIDTH,
    parameter int CNT_W    = $clog2(MAX_ITER + 1)
) (
    input  logic             clk_i,
    input  logic             nreset_i,
    input  logic             clear_i,
    input  logic             start_i,
    output logic             ready_o,
    input  logic             mode_i,
    input  logic [WIDTH-1:0] operand_a_i,
    input  logic [WIDTH-1:0] operand_b_i,
    output logic             busy_o,
    output logic [WIDTH-1:0] gcd_o,
    output logic             gcd_valid_o,
    input  logic             gcd_ready_i,
    output logic             gcd_error_o,
    output logic [CNT_W-1:0] iter_count_o
);

    localparam int K_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [K_W-1:0]   k_q, k_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] gcd_q, gcd_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] iter_q, iter_d;

    // One algorithm step, evaluated combinationally from the working registers.
    logic             term;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] a_step, b_step;
    logic [K_W-1:0]   k_step;
    logic [WIDTH-1:0] diff_ab, diff_ba;
    logic [CNT_W-1:0] cnt_inc;
    logic             last_iter;

    always_comb begin
        term    = 1'b0;
        result  = '0;
        a_step  = a_q;
        b_step  = b_q;
        k_step  = k_q;
        diff_ab = a_q - b_q;
        diff_ba = b_q - a_q;
        if (a_q == '0 || b_q == '0) begin
            term = 1'b1;
            // Stein restores the common factor of two removed while halving.
            result = mode_q ? ((a_q | b_q) << k_q) : (a_q | b_q);
        end else if (!mode_q) begin
            if (a_q >= b_q) begin
                a_step = diff_ab;
            end else begin
                b_step = diff_ba;
            end
        end else if (!a_q[0] && !b_q[0]) begin
            a_step = a_q >> 1;
            b_step = b_q >> 1;
            k_step = k_q + K_W'(1);
        end else if (!a_q[0]) begin
            a_step = a_q >> 1;
        end else if (!b_q[0]) begin
            b_step = b_q >> 1;
        end else if (a_q >= b_q) begin
            // Difference of two odd values is even, so halving is exact.
            a_step = diff_ab >> 1;
        end else begin
            b_step = diff_ba >> 1;
        end
    end

    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign last_iter = (cnt_inc == CNT_W'(MAX_ITER));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        k_d     = k_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        gcd_d   = gcd_q;
        err_d   = err_q;
        iter_d  = iter_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!clear_i && start_i) begin
                    a_d     = operand_a_i;
                    b_d     = operand_b_i;
                    mode_d  = mode_i;
                    k_d     = '0;
                    cnt_d   = '0;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                if (clear_i) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                    if (term) begin
                        // A result found on the final allowed cycle wins over timeout.
                        gcd_d   = result;
                        err_d   = 1'b0;
                        iter_d  = cnt_inc;
                        state_d = ST_DONE;
                    end else if (last_iter) begin
                        gcd_d   = '0;
                        err_d   = 1'b1;
                        iter_d  = CNT_W'(MAX_ITER);
                        state_d = ST_DONE;
                    end else begin
                        a_d = a_step;
                        b_d = b_step;
                        k_d = k_step;
                    end
                end
            end
            ST_DONE: begin
                if (clear_i || gcd_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            k_q     <= '0;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
            gcd_q   <= '0;
            err_q   <= 1'b0;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            k_q     <= k_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            gcd_q   <= gcd_d;
            err_q   <= err_d;
            iter_q  <= iter_d;
        end
    end

    assign ready_o      = (state_q == ST_IDLE);
    assign busy_o       = (state_q == ST_CALC);
    assign gcd_valid_o  = (state_q == ST_DONE);
    assign gcd_o        = gcd_q;
    assign gcd_error_o  = err_q;
    assign iter_count_o = iter_q;

endmodule

// File: tb/tb_gcd_multimode_engine.sv
// Self-checking bench for gcd_multimode_engine: directed scenarios plus
// randomized operations compared with an arithmetic reference model.
module tb_gcd_multimode_engine;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         nreset = 1'b0;
    logic         clear = 1'b0;
    logic         start = 1'b0;
    logic         mode = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         gcd_ready = 1'b0;

    logic         ready, busy, valid, err;
    logic [W-1:0] gcd;
    logic [8:0]   iter;

    // Second instance with a short iteration bound for the timeout scenario.
    logic         start_t = 1'b0;
    logic         gcd_ready_t = 1'b0;
    logic         ready_t, busy_t, valid_t, err_t;
    logic [W-1:0] gcd_t;
    logic [2:0]   iter_t;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gcd_multimode_engine #(.WIDTH(W)) dut (
        .clk_i(clk), .nreset_i(nreset), .clear_i(clear), .start_i(start),
        .ready_o(ready), .mode_i(mode), .operand_a_i(op_a), .operand_b_i(op_b),
        .busy_o(busy), .gcd_o(gcd), .gcd_valid_o(valid), .gcd_ready_i(gcd_ready),
        .gcd_error_o(err), .iter_count_o(iter)
    );

    gcd_multimode_engine #(.WIDTH(W), .MAX_ITER(4)) dut_to (
        .clk_i(clk), .nreset_i(nreset), .clear_i(clear), .start_i(start_t),
        .ready_o(ready_t), .mode_i(mode), .operand_a_i(op_a), .operand_b_i(op_b),
        .busy_o(busy_t), .gcd_o(gcd_t), .gcd_valid_o(valid_t), .gcd_ready_i(gcd_ready_t),
        .gcd_error_o(err_t), .iter_count_o(iter_t)
    );

    // Reference: true GCD from Euclid's modulo form, scaled into the
    // engine's step counts using the algorithm rules on plain integers.
    function automatic int true_gcd(input int a, input int b);
        int x = a, y = b, t;
        while (y != 0) begin t = x % y; x = y; y = t; end
        return x;
    endfunction

    function automatic void model(input int a, input int b, input int m, input int max_it,
                                  output int g, output int e, output int it);
        int x = a, y = b, n = 0, k = 0;
        forever begin
            n++;
            if (x == 0 || y == 0) begin
                g = m ? (((x | y) * (1 << k)) % 256) : (x | y);
                e = 0; it = n; return;
            end
            if (n == max_it) begin g = 0; e = 1; it = max_it; return; end
            if (m == 0) begin
                if (x >= y) x = x - y; else y = y - x;
            end else if (x % 2 == 0 && y % 2 == 0) begin
                x = x / 2; y = y / 2; k++;
            end else if (x % 2 == 0) x = x / 2;
            else if (y % 2 == 0) y = y / 2;
            else if (x >= y) x = (x - y) / 2;
            else y = (y - x) / 2;
        end
    endfunction

    // Drives one operation on the main instance and waits for the result.
    task automatic do_op(input int a, input int b, input int m,
                         output int g, output int e, output int it, output int lat, output bit ok);
        op_a = a[W-1:0]; op_b = b[W-1:0]; mode = m[0]; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (valid !== 1'b1 && lat < 400) begin @(posedge clk); #1; lat++; end
        ok = (valid === 1'b1);
        g = int'(gcd); e = int'(err); it = int'(iter);
    endtask

    task automatic release_op();
        gcd_ready = 1'b1;
        @(posedge clk); #1;
        gcd_ready = 1'b0;
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        #2;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", valid); end
        checks++; if (gcd !== 8'd0 || err !== 1'b0 || iter !== 9'd0) begin
            errors++; $display("FAIL reset_regs got gcd=%0d err=%0b iter=%0d want 0/0/0", gcd, err, iter); end
        @(negedge clk); nreset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int g, e, it, lat; bit ok;
        do_op(48, 18, 0, g, e, it, lat, ok);
        checks++; if (!ok || g != 6 || e != 0 || it != 6) begin errors++;
            $display("FAIL euclid_48_18 got ok=%0b gcd=%0d err=%0d iter=%0d want 1/6/0/6", ok, g, e, it); end
        checks++; if (lat != 6) begin errors++; $display("FAIL euclid_latency got %0d want 6", lat); end
        release_op();
        do_op(48, 18, 1, g, e, it, lat, ok);
        checks++; if (!ok || g != 6 || e != 0 || it != 7) begin errors++;
            $display("FAIL stein_48_18 got ok=%0b gcd=%0d err=%0d iter=%0d want 1/6/0/7", ok, g, e, it); end
        checks++; if (lat != 7) begin errors++; $display("FAIL stein_latency got %0d want 7", lat); end
        release_op();
    endtask

    task automatic test_zero();
        int za[3] = '{0, 0, 35};
        int zb[3] = '{0, 35, 0};
        int zg[3] = '{0, 35, 35};
        int g, e, it, lat; bit ok;
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 3; i++) begin
                do_op(za[i], zb[i], m, g, e, it, lat, ok);
                checks++; if (!ok || g != zg[i] || e != 0 || it != 1 || lat != 1) begin errors++;
                    $display("FAIL zero_m%0d_%0d got ok=%0b gcd=%0d err=%0d iter=%0d lat=%0d want gcd=%0d err=0 iter=1 lat=1",
                             m, i, ok, g, e, it, lat, zg[i]); end
                release_op();
            end
        end
    endtask

    task automatic test_boundary();
        int g, e, it, lat; bit ok;
        // Terminates exactly on the 256th (last allowed) cycle: no error.
        do_op(255, 1, 0, g, e, it, lat, ok);
        checks++; if (!ok || g != 1 || e != 0 || it != 256 || lat != 256) begin errors++;
            $display("FAIL last_cycle_term got ok=%0b gcd=%0d err=%0d iter=%0d lat=%0d want 1/1/0/256/256", ok, g, e, it, lat); end
        release_op();
    endtask

    task automatic test_timeout();
        int lat = 0;
        op_a = 8'd48; op_b = 8'd18; mode = 1'b0; start_t = 1'b1;
        @(posedge clk); #1;
        start_t = 1'b0;
        while (valid_t !== 1'b1 && lat < 50) begin @(posedge clk); #1; lat++; end
        checks++; if (valid_t !== 1'b1 || err_t !== 1'b1 || gcd_t !== 8'd0 || iter_t !== 3'd4) begin errors++;
            $display("FAIL timeout got valid=%0b err=%0b gcd=%0d iter=%0d want 1/1/0/4", valid_t, err_t, gcd_t, iter_t); end
        checks++; if (lat != 4) begin errors++; $display("FAIL timeout_latency got %0d want 4", lat); end
        gcd_ready_t = 1'b1; @(posedge clk); #1; gcd_ready_t = 1'b0;
        checks++; if (ready_t !== 1'b1) begin errors++; $display("FAIL timeout_release got %0b want 1", ready_t); end
    endtask

    task automatic test_handshake();
        int g, e, it, lat; bit ok;
        do_op(48, 18, 0, g, e, it, lat, ok);
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin op_a = 8'd9; op_b = 8'd3; start = 1'b1; end
            else start = 1'b0;
            @(posedge clk); #1;
            checks++; if (gcd !== 8'd6 || ready !== 1'b0 || valid !== 1'b1) begin errors++;
                $display("FAIL hold_c%0d got gcd=%0d ready=%0b valid=%0b want 6/0/1", c, gcd, ready, valid); end
        end
        start = 1'b0;
        release_op();
        checks++; if (ready !== 1'b1 || valid !== 1'b0 || busy !== 1'b0 || gcd !== 8'd6) begin errors++;
            $display("FAIL hold_release got ready=%0b valid=%0b busy=%0b gcd=%0d want 1/0/0/6", ready, valid, busy, gcd); end
    endtask

    task automatic test_clear();
        int g, e, it, lat; bit ok;
        bit rose = 1'b0;
        op_a = 8'd255; op_b = 8'd1; mode = 1'b0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1; clear = 1'b0;
        checks++; if (ready !== 1'b1 || busy !== 1'b0 || valid !== 1'b0) begin errors++;
            $display("FAIL clear_calc got ready=%0b busy=%0b valid=%0b want 1/0/0", ready, busy, valid); end
        checks++; if (gcd !== 8'd6 || iter !== 9'd6 || err !== 1'b0) begin errors++;
            $display("FAIL clear_keep got gcd=%0d iter=%0d err=%0b want 6/6/0", gcd, iter, err); end
        for (int c = 0; c < 10; c++) begin @(posedge clk); #1; if (valid === 1'b1) rose = 1'b1; end
        checks++; if (rose) begin errors++; $display("FAIL clear_no_valid got rose=1 want 0"); end
        do_op(12, 8, 1, g, e, it, lat, ok);
        checks++; if (!ok || g != 4 || e != 0) begin errors++;
            $display("FAIL after_clear got ok=%0b gcd=%0d err=%0d want 1/4/0", ok, g, e); end
        release_op();
        // Clear while the result is waiting: result registers must survive.
        do_op(9, 3, 0, g, e, it, lat, ok);
        clear = 1'b1;
        @(posedge clk); #1; clear = 1'b0;
        checks++; if (ready !== 1'b1 || valid !== 1'b0 || gcd !== 8'd3 || iter !== 9'd4) begin errors++;
            $display("FAIL clear_done got ready=%0b valid=%0b gcd=%0d iter=%0d want 1/0/3/4", ready, valid, gcd, iter); end
        // Clear together with start in IDLE discards the operands.
        op_a = 8'd9; op_b = 8'd6; start = 1'b1; clear = 1'b1;
        @(posedge clk); #1; start = 1'b0; clear = 1'b0;
        checks++; if (ready !== 1'b1 || busy !== 1'b0) begin errors++;
            $display("FAIL clear_start got ready=%0b busy=%0b want 1/0", ready, busy); end
    endtask

    task automatic test_reset_mid();
        int g, e, it, lat; bit ok;
        op_a = 8'd255; op_b = 8'd1; mode = 1'b0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        nreset = 1'b0;
        #1;
        checks++; if (ready !== 1'b1 || busy !== 1'b0 || valid !== 1'b0 || gcd !== 8'd0 || err !== 1'b0 || iter !== 9'd0) begin
            errors++; $display("FAIL reset_mid got ready=%0b busy=%0b valid=%0b gcd=%0d err=%0b iter=%0d want 1/0/0/0/0/0",
                               ready, busy, valid, gcd, err, iter); end
        @(negedge clk); nreset = 1'b1;
        @(posedge clk); #1;
        do_op(12, 8, 1, g, e, it, lat, ok);
        checks++; if (!ok || g != 4 || e != 0) begin errors++;
            $display("FAIL after_reset got ok=%0b gcd=%0d err=%0d want 1/4/0", ok, g, e); end
        release_op();
    endtask

    task automatic test_random();
        int a, b, m, g, e, it, lat, eg, ee, eit; bit ok;
        for (int n = 0; n < 40; n++) begin
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 255));
            m = int'($urandom_range(0, 1));
            model(a, b, m, 256, eg, ee, eit);
            do_op(a, b, m, g, e, it, lat, ok);
            checks++; if (!ok || g != eg || e != ee || it != eit || lat != eit) begin errors++;
                $display("FAIL random_%0d a=%0d b=%0d m=%0d got ok=%0b gcd=%0d err=%0d iter=%0d lat=%0d want gcd=%0d err=%0d iter=%0d",
                         n, a, b, m, ok, g, e, it, lat, eg, ee, eit); end
            checks++; if (ee == 0 && g != true_gcd(a, b)) begin errors++;
                $display("FAIL random_gcd_%0d got %0d want %0d", n, g, true_gcd(a, b)); end
            release_op();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_boundary();
        test_timeout();
        test_handshake();
        test_clear();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
